// File: rtl/mips_abb_pkg.sv
// Shared pipeline-control types: per-stage hold vector, hold/reset levels,
// controller state encoding and stage indices into the hold vector.
package mips_abb_pkg;
  typedef logic [5:0] stack;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;
  localparam logic RESET  = 1'b1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } ctrl_state_t;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
endpackage

// File: rtl/mc_counter.sv
// Down-counter tracking remaining EX occupancy of a multi-cycle op.
// Load wins over decrement, clear wins over both; never wraps below zero.
module mc_counter #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [MC_CNT_W-1:0] i_load_val,
  input  logic                i_dec,
  output logic [MC_CNT_W-1:0] o_cnt,
  output logic                o_zero
);
  logic [MC_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - MC_CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: combinational per-stage stall from the
// deepest stalled stage, plus a RUN/MC_WAIT/FLUSH sequencer for EX and flushes.
module pipe_ctrl
  import mips_abb_pkg::*;
#(
  parameter int MC_CNT_W = 6
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                if_bus_req,
  input  logic                if_bus_ack,
  input  logic                id_stallreq,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                mem_bus_req,
  input  logic                mem_bus_ack,
  input  logic                flush_req,
  output stack                stop,
  output logic                flush,
  output logic                mc_busy
);
  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic                w_load;
  logic                w_mc_long;
  logic                w_cnt_zero;
  logic [MC_CNT_W-1:0] w_cnt;
  logic [MC_CNT_W-1:0] w_load_val;
  logic                w_in_rst;
  logic                w_s_if, w_s_id, w_s_ex, w_s_mem;

  assign w_in_rst   = (cpu_rst == RESET);
  assign w_mc_long  = (ex_mc_cycles >= MC_CNT_W'(2));
  assign w_load_val = ex_mc_cycles - MC_CNT_W'(1);

  always_ff @(posedge cpu_clk) begin
    if (w_in_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_mc_start && w_mc_long) begin
          w_state_nxt = MC_WAIT;
          w_load      = 1'b1;
        end
      end
      // Leave on the edge where the counter drops to zero so a new op can start right away.
      MC_WAIT: begin
        if (w_cnt <= MC_CNT_W'(1)) begin
          w_state_nxt = RUN;
        end
      end
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (flush_req) begin
      w_state_nxt = FLUSH;
      w_load      = 1'b0;
    end
  end

  mc_counter #(
    .MC_CNT_W(MC_CNT_W)
  ) u_mc_counter (
    .clk        (cpu_clk),
    .rst        (w_in_rst),
    .i_clr      (flush_req),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (1'b1),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  assign mc_busy = ~w_cnt_zero;
  assign flush   = (r_state == FLUSH) && !w_in_rst;

  // Bus stalls are never latched: they exist only while req is high and ack low.
  assign w_s_mem = mem_bus_req & ~mem_bus_ack;
  assign w_s_ex  = mc_busy;
  assign w_s_id  = id_stallreq;
  assign w_s_if  = if_bus_req & ~if_bus_ack;

  always_comb begin
    stop = {6{NOSTOP}};
    if (!w_in_rst && (r_state != FLUSH)) begin
      if (w_s_mem) begin
        stop[STAGE_MEM:0] = {(STAGE_MEM + 1){STOP}};
      end else if (w_s_ex) begin
        stop[STAGE_EX:0] = {(STAGE_EX + 1){STOP}};
      end else if (w_s_id) begin
        stop[STAGE_ID:0] = {(STAGE_ID + 1){STOP}};
      end else if (w_s_if) begin
        stop[STAGE_IF] = STOP;
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random checks of pipe_ctrl against a cycle-count reference model.
module tb_pipe_ctrl;
  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic       if_bus_req, if_bus_ack, id_stallreq, ex_mc_start;
  logic [5:0] ex_mc_cycles;
  logic       mem_bus_req, mem_bus_ack, flush_req;
  logic [5:0] stop;
  logic       flush, mc_busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: remaining busy cycles and whether the current cycle is the flush cycle.
  int m_rem = 0;
  bit m_fl  = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_ctrl #(.MC_CNT_W(6)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .if_bus_req   (if_bus_req),
    .if_bus_ack   (if_bus_ack),
    .id_stallreq  (id_stallreq),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .mem_bus_req  (mem_bus_req),
    .mem_bus_ack  (mem_bus_ack),
    .flush_req    (flush_req),
    .stop         (stop),
    .flush        (flush),
    .mc_busy      (mc_busy)
  );

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance model at the rising edge.
  // xs >= 0 additionally pins stop to a hand-computed value.
  task automatic step(input logic rst_v, input logic ifr, input logic ifa, input logic ids,
                      input logic mcs, input logic [5:0] mcc, input logic memr,
                      input logic mema, input logic flr, input int xs, input string tag);
    int        k;
    bit        busy;
    logic [5:0] e_stop;
    @(negedge cpu_clk);
    cpu_rst = rst_v; if_bus_req = ifr; if_bus_ack = ifa; id_stallreq = ids;
    ex_mc_start = mcs; ex_mc_cycles = mcc; mem_bus_req = memr; mem_bus_ack = mema;
    flush_req = flr;
    #1;
    busy = (m_rem > 0);
    k = -1;
    if (ifr && !ifa) k = 0;
    if (ids)         k = 1;
    if (busy)        k = 2;
    if (memr && !mema) k = 3;
    if (rst_v || m_fl) k = -1;
    e_stop = 6'((1 << (k + 1)) - 1);
    check({tag, ".stop"}, stop, e_stop);
    check({tag, ".flush"}, {5'b0, flush}, {5'b0, m_fl && !rst_v});
    check({tag, ".mc_busy"}, {5'b0, mc_busy}, {5'b0, busy});
    if (xs >= 0) check({tag, ".stop_dir"}, stop, 6'(xs));
    @(posedge cpu_clk);
    if (rst_v) begin
      m_rem = 0; m_fl = 1'b0;
    end else if (flr) begin
      m_rem = 0; m_fl = 1'b1;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1; m_fl = 1'b0;
    end else begin
      if (mcs && !m_fl && mcc >= 2) m_rem = int'(mcc) - 1;
      m_fl = 1'b0;
    end
  endtask

  task automatic idle(input int xs, input string tag);
    step(0, 0, 0, 0, 0, 6'd0, 0, 0, 0, xs, tag);
  endtask

  initial begin
    cpu_rst = 1; if_bus_req = 0; if_bus_ack = 0; id_stallreq = 0; ex_mc_start = 0;
    ex_mc_cycles = 0; mem_bus_req = 0; mem_bus_ack = 0; flush_req = 0;
    repeat (2) @(posedge cpu_clk);

    // Reset holds stop inactive even with every stall source asserted.
    step(1, 1, 0, 1, 0, 6'd0, 1, 0, 0, 0, "rst_all");
    idle(0, "post_rst");

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 6'd0, 0, 0, 0, 6'b000001, "if_wait");
    step(0, 1, 1, 0, 0, 6'd0, 0, 0, 0, 0, "if_ack");

    step(0, 0, 0, 1, 0, 6'd0, 0, 0, 0, 6'b000011, "id_stall");
    idle(0, "id_done");

    step(0, 0, 0, 0, 1, 6'd5, 0, 0, 0, 0, "mc5_start");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 6'b000111, "mc5_busy");
    idle(0, "mc5_done");
    step(0, 0, 0, 0, 1, 6'd1, 0, 0, 0, 0, "mc1_start");
    idle(0, "mc1_none");
    step(0, 0, 0, 0, 1, 6'd0, 0, 0, 0, 0, "mc0_start");
    idle(0, "mc0_none");

    step(0, 0, 0, 1, 0, 6'd0, 1, 0, 0, 6'b001111, "mem_dom");

    // Memory stall during MC_WAIT still drains the counter; a second start is ignored.
    step(0, 0, 0, 0, 1, 6'd4, 0, 0, 0, 0, "mc4_start");
    step(0, 0, 0, 0, 1, 6'd9, 1, 0, 0, 6'b001111, "mc4_mem");
    step(0, 0, 0, 0, 0, 6'd0, 1, 0, 0, 6'b001111, "mc4_mem2");
    step(0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 6'b000111, "mc4_last");
    idle(0, "mc4_done");

    step(0, 0, 0, 0, 1, 6'd5, 0, 0, 0, 0, "fl_start");
    idle(6'b000111, "fl_cnt4");
    step(0, 0, 0, 0, 0, 6'd0, 0, 0, 1, 6'b000111, "fl_req_cnt3");
    step(0, 1, 0, 1, 0, 6'd0, 1, 0, 0, 0, "fl_cycle");
    idle(0, "fl_run");

    step(0, 0, 0, 0, 1, 6'd6, 0, 0, 0, 0, "rst_mc_start");
    idle(6'b000111, "rst_mc_busy");
    step(1, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0, "rst_mc");
    idle(0, "rst_mc_after");
    step(0, 0, 0, 0, 1, 6'd2, 0, 0, 0, 0, "rst_mc_run");
    idle(6'b000111, "rst_mc_run_busy");
    idle(0, "rst_mc_run_done");

    step(0, 0, 0, 0, 0, 6'd0, 0, 0, 1, -1, "rst_fl_req");
    step(1, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0, "rst_in_flush");
    idle(0, "rst_fl_after");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 6'($urandom_range(0, 12)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
